// File: rtl/sprint1_sel_reg.sv
// Registered 2:1 word selector driving the LED bus, with source and equality status flags.
// Every output is a flop; inputs are sampled only on the rising edge of clk.
module sprint1_sel_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             switch,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       src,
  output logic             eq
);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_IN1  = 2'b01;
  localparam logic [1:0] SRC_IN2  = 2'b10;

  logic [WIDTH-1:0] sel_c;
  logic [1:0]       src_c;
  logic             eq_c;

  // Next values; the if/else keeps an unknown unselected operand out of sel_c.
  always_comb begin
    sel_c = in1;
    src_c = SRC_IN1;
    eq_c  = (in1 == in2);
    if (switch) begin
      sel_c = in2;
      src_c = SRC_IN2;
    end
  end

  // Synchronous reset has priority over the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      src <= SRC_NONE;
      eq  <= 1'b0;
    end else if (en) begin
      out <= sel_c;
      src <= src_c;
      eq  <= eq_c;
    end
  end

endmodule

// File: tb/tb_sprint1_sel_reg.sv
// Bench for sprint1_sel_reg: directed plan steps followed by random traffic
// compared against a small reference model of the visible outputs.
module tb_sprint1_sel_reg;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] in1 = '0;
  logic [WIDTH-1:0] in2 = '0;
  logic             switch = 1'b0;
  logic [WIDTH-1:0] out;
  logic [1:0]       src;
  logic             eq;

  int ncmp = 0;
  int nfail = 0;

  // Reference state: what the LED bus and flags should show right now.
  logic [WIDTH-1:0] m_out;
  logic [1:0]       m_src;
  logic             m_eq;
  bit               m_valid = 1'b0;

  sprint1_sel_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .in1(in1), .in2(in2),
    .switch(switch), .out(out), .src(src), .eq(eq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the shown word is picked from an operand table by the switch,
  // and the source code is the 1-based operand number written as one-hot.
  task automatic model_edge(input logic r, input logic e, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic s);
    logic [WIDTH-1:0] ops [2];
    int idx;
    ops[0] = a;
    ops[1] = b;
    idx = int'(s);
    if (r) begin
      m_out = '0;
      m_src = 2'd0;
      m_eq  = 1'b0;
    end else if (e) begin
      m_out = ops[idx];
      m_src = 2'(idx + 1);
      m_eq  = (int'(a) - int'(b)) == 0;
    end
    if (r || e) m_valid = 1'b1;
  endtask

  // Drive, confirm nothing moves before the edge, clock, then check the result.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    rst = r; en = e; in1 = a; in2 = b; switch = s;
    #1;
    if (m_valid) begin
      chk({tag, "/pre_out"}, 32'(out), 32'(m_out));
      chk({tag, "/pre_src"}, 32'(src), 32'(m_src));
    end
    @(posedge clk);
    model_edge(r, e, a, b, s);
    #1;
    if (m_valid) begin
      chk({tag, "/out"}, 32'(out), 32'(m_out));
      chk({tag, "/src"}, 32'(src), 32'(m_src));
      chk({tag, "/eq"},  32'(eq),  32'(m_eq));
    end
  endtask

  initial begin
    @(negedge clk);
    // Reset for two cycles with arbitrary inputs.
    step("rst0", 1'b1, 1'b1, 4'd9, 4'd9, 1'b1);
    step("rst1", 1'b1, 1'b0, 4'd3, 4'd12, 1'b0);
    chk("rst_out_const", 32'(out), 32'd0);
    chk("rst_src_const", 32'(src), 32'd0);
    chk("rst_eq_const",  32'(eq),  32'd0);

    // Select in1.
    step("sel1a", 1'b0, 1'b1, 4'd3, 4'd1, 1'b0);
    chk("sel1a_const", 32'(out), 32'h3);
    step("sel1b", 1'b0, 1'b1, 4'd15, 4'd2, 1'b0);
    chk("sel1b_const", 32'(out), 32'hf);

    // Select in2.
    step("sel2a", 1'b0, 1'b1, 4'd7, 4'd3, 1'b1);
    chk("sel2a_src_const", 32'(src), 32'h2);
    step("sel2b", 1'b0, 1'b1, 4'd7, 4'd8, 1'b1);
    chk("sel2b_const", 32'(out), 32'h8);

    // Equality then hold for three cycles with changed inputs.
    step("eq", 1'b0, 1'b1, 4'd5, 4'd5, 1'b0);
    chk("eq_const", 32'(eq), 32'd1);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 4'd9, 4'd5, 1'b1);
    chk("hold_out_const", 32'(out), 32'h5);
    chk("hold_src_const", 32'(src), 32'h1);
    chk("hold_eq_const",  32'(eq),  32'd1);

    // Mid-stream reset pulse, then recovery.
    step("rstpulse", 1'b1, 1'b1, 4'd10, 4'd6, 1'b0);
    chk("rstpulse_const", 32'(out), 32'd0);
    step("recover", 1'b0, 1'b1, 4'd10, 4'd6, 1'b0);
    chk("recover_const", 32'(out), 32'ha);

    // Switch toggled between edges only takes effect at the next edge.
    step("tog0", 1'b0, 1'b1, 4'd1, 4'd14, 1'b0);
    #2 switch = 1'b1;
    #1 chk("tog_mid_out", 32'(out), 32'h1);
    #1 switch = 1'b0;
    #1 switch = 1'b1;
    @(posedge clk);
    model_edge(1'b0, 1'b1, 4'd1, 4'd14, 1'b1);
    #1 chk("tog_edge_out", 32'(out), 32'he);
    chk("tog_edge_src", 32'(src), 32'h2);

    // Unknown on the unselected operand must not reach out.
    rst = 1'b0; en = 1'b1; in1 = 4'd6; in2 = 'x; switch = 1'b0;
    @(posedge clk);
    #1 chk("x_out", 32'(out), 32'h6);
    chk("x_src", 32'(src), 32'h1);
    m_valid = 1'b0;
    step("x_clear", 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(15) == 0), ($urandom_range(3) != 0),
           WIDTH'($urandom), WIDTH'($urandom_range(3) == 0 ? in1 : $urandom),
           1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
